// File: rtl/timed_output_sequencer.sv
// Multi-channel timed output scheduler: armed channels load their value when
// their cycle offset elapses after start. Define TSEQ_RELATIVE_EN for chained mode.
module timed_output_sequencer #(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 5,
  parameter int TIME_W   = 8,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [CH_W-1:0]           cfg_ch,
  input  logic                      cfg_arm,
  input  logic [TIME_W-1:0]         cfg_time,
  input  logic [WIDTH-1:0]          cfg_value,
  input  logic                      start,
  input  logic                      abort,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic [CHANNELS-1:0]       fired,
  output logic                      busy,
  output logic                      done,
  output logic                      dbg_state
);

  // Handshake: no valid/ready; cfg_we is a single-cycle write strobe honoured
  // only in IDLE, start is a level sampled in IDLE, abort is sampled in RUN.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [TIME_W-1:0] CNT_MAX = {TIME_W{1'b1}};

  state_t              state, state_next;
  logic [TIME_W-1:0]   count;
  logic [WIDTH-1:0]    out_r [CHANNELS];

  // Programmed configuration and the copy a run executes from; the run copy
  // is captured at start so a same-cycle config write affects only later runs.
  logic [CHANNELS-1:0] cfg_armed;
  logic [TIME_W-1:0]   cfg_time_r [CHANNELS];
  logic [WIDTH-1:0]    cfg_value_r [CHANNELS];
  logic [CHANNELS-1:0] run_armed;
  logic [TIME_W-1:0]   run_time [CHANNELS];
  logic [WIDTH-1:0]    run_value [CHANNELS];

  logic [CHANNELS-1:0] match;
  logic                finish;
  logic                cfg_hit;

`ifdef TSEQ_RELATIVE_EN
  logic [CH_W-1:0]     ptr;
  logic [CH_W-1:0]     nxt;
  logic                nxt_found;
  logic [CH_W-1:0]     first_armed;
`endif

  assign cfg_hit = cfg_we && ({1'b0, cfg_ch} < (CH_W+1)'(CHANNELS));

  always_comb begin
    state_next = state;
    match      = '0;
    finish     = 1'b0;
`ifdef TSEQ_RELATIVE_EN
    nxt         = ptr;
    nxt_found   = 1'b0;
    first_armed = '0;
    if (run_armed[ptr] && (run_time[ptr] == count))
      match[ptr] = 1'b1;
    // Descending scan so the lowest qualifying index wins.
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if ((CH_W'(i) > ptr) && run_armed[i]) begin
        nxt       = CH_W'(i);
        nxt_found = 1'b1;
      end
      if (cfg_armed[i])
        first_armed = CH_W'(i);
    end
    finish = (run_armed == '0) || ((match != '0) && !nxt_found) ||
             ((match == '0) && (count == CNT_MAX));
`else
    for (int i = 0; i < CHANNELS; i++)
      match[i] = run_armed[i] && (run_time[i] == count);
    finish = ((run_armed & ~fired & ~match) == '0) || (count == CNT_MAX);
`endif
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (abort || finish) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      fired     <= '0;
      done      <= 1'b0;
      cfg_armed <= '0;
      run_armed <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        out_r[i]       <= '0;
        cfg_time_r[i]  <= '0;
        cfg_value_r[i] <= '0;
        run_time[i]    <= '0;
        run_value[i]   <= '0;
      end
`ifdef TSEQ_RELATIVE_EN
      ptr <= '0;
`endif
    end else begin
      state <= state_next;
      done  <= 1'b0;
      if (state == IDLE) begin
        if (cfg_hit) begin
          cfg_armed[cfg_ch]   <= cfg_arm;
          cfg_time_r[cfg_ch]  <= cfg_time;
          cfg_value_r[cfg_ch] <= cfg_value;
        end
        if (start) begin
          fired     <= '0;
          count     <= '0;
          run_armed <= cfg_armed;
          run_time  <= cfg_time_r;
          run_value <= cfg_value_r;
`ifdef TSEQ_RELATIVE_EN
          ptr <= first_armed;
`endif
        end
      end else if (!abort) begin
        for (int i = 0; i < CHANNELS; i++)
          if (match[i]) out_r[i] <= run_value[i];
        fired <= fired | match;
        if (finish) done <= 1'b1;
`ifdef TSEQ_RELATIVE_EN
        if (match != '0) begin
          count <= '0;
          ptr   <= nxt;
        end else if (count != CNT_MAX) begin
          count <= count + 1'b1;
        end
`else
        if (count != CNT_MAX) count <= count + 1'b1;
`endif
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign out[g*WIDTH +: WIDTH] = out_r[g];
  end

  assign busy      = (state == RUN);
  assign dbg_state = state;

endmodule

// File: tb/tb_timed_output_sequencer.sv
// Bench for timed_output_sequencer: directed and random runs compared against a
// schedule model that predicts the edge on which each channel fires.
module tb_timed_output_sequencer;

  localparam int W = 3;
  localparam int C = 5;
  localparam int T = 8;
  localparam int CW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_we = 1'b0;
  logic [CW-1:0]  cfg_ch = '0;
  logic           cfg_arm = 1'b0;
  logic [T-1:0]   cfg_time = '0;
  logic [W-1:0]   cfg_value = '0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [C*W-1:0] out;
  logic [C-1:0]   fired;
  logic           busy;
  logic           done;
  logic           dbg_state;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic           m_armed [C];
  logic [T-1:0]   m_time [C];
  logic [W-1:0]   m_value [C];
  logic [W-1:0]   m_out [C];
  logic [C-1:0]   m_fired;

  timed_output_sequencer #(.WIDTH(W), .CHANNELS(C), .TIME_W(T)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_arm(cfg_arm), .cfg_time(cfg_time), .cfg_value(cfg_value),
    .start(start), .abort(abort), .out(out), .fired(fired), .busy(busy),
    .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [C*W-1:0] pack_out();
    logic [C*W-1:0] r;
    for (int i = 0; i < C; i++) r[i*W +: W] = m_out[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < C; i++) begin
      m_armed[i] = 1'b0; m_time[i] = '0; m_value[i] = '0; m_out[i] = '0;
    end
    m_fired = '0;
  endtask

  task automatic model_cfg(input int ch, input logic arm, input logic [T-1:0] t,
                           input logic [W-1:0] v);
    if (ch < C) begin
      m_armed[ch] = arm; m_time[ch] = t; m_value[ch] = v;
    end
  endtask

  task automatic check_all(input string tag, input logic exp_busy, input logic exp_done);
    check({tag, ".busy"}, 64'(busy), 64'(exp_busy));
    check({tag, ".done"}, 64'(done), 64'(exp_done));
    check({tag, ".fired"}, 64'(fired), 64'(m_fired));
    check({tag, ".out"}, 64'(out), 64'(pack_out()));
  endtask

  task automatic cfg_write(input int ch, input logic arm, input int t, input int v);
    cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_arm = arm;
    cfg_time = T'(t); cfg_value = W'(v);
    tick();
    cfg_we = 1'b0;
    model_cfg(ch, arm, T'(t), W'(v));
  endtask

  task automatic disarm_all();
    for (int i = 0; i < C; i++) cfg_write(i, 1'b0, 0, 0);
  endtask

  // One run: fire edges are computed from the configuration captured at start.
  task automatic run(input string tag, input bit may_abort, input bit wr_during,
                     input bit wr_with_start);
    logic         s_armed [C];
    logic [T-1:0] s_time [C];
    logic [W-1:0] s_value [C];
    int fire_e [C];
    int done_e, abort_at, prev, ch;
    done_e = 1; prev = 0;
    for (int i = 0; i < C; i++) begin
      s_armed[i] = m_armed[i]; s_time[i] = m_time[i]; s_value[i] = m_value[i];
      fire_e[i] = 0;
      if (s_armed[i]) begin
`ifdef TSEQ_RELATIVE_EN
        fire_e[i] = prev + int'(s_time[i]) + 1;
        prev = fire_e[i];
`else
        fire_e[i] = int'(s_time[i]) + 1;
`endif
        if (fire_e[i] > done_e) done_e = fire_e[i];
      end
    end
    abort_at = may_abort ? int'($urandom_range(1, done_e)) : 0;
    if (wr_with_start) begin
      ch = int'($urandom_range(0, C - 1));
      cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_arm = 1'($urandom);
      cfg_time = T'($urandom_range(0, 30)); cfg_value = W'($urandom);
      model_cfg(ch, cfg_arm, cfg_time, cfg_value);
    end
    start = 1'b1;
    tick();
    start = 1'b0; cfg_we = 1'b0;
    m_fired = '0;
    check_all({tag, ".e0"}, 1'b1, 1'b0);
    for (int k = 1; k <= done_e + 1; k++) begin
      if (k == abort_at) abort = 1'b1;
      if (wr_during && k == 1) begin
        cfg_we = 1'b1; cfg_ch = CW'($urandom_range(0, C - 1)); cfg_arm = 1'b1;
        cfg_time = T'($urandom_range(0, 20)); cfg_value = W'($urandom);
      end
      tick();
      abort = 1'b0; cfg_we = 1'b0;
      if (k == abort_at) begin
        check_all({tag, ".abort"}, 1'b0, 1'b0);
        tick();
        check_all({tag, ".post_abort"}, 1'b0, 1'b0);
        break;
      end
      for (int i = 0; i < C; i++)
        if (fire_e[i] == k) begin
          m_out[i] = s_value[i];
          m_fired[i] = 1'b1;
        end
      check_all(tag, k < done_e, k == done_e);
    end
  endtask

  initial begin
    model_reset();
    // Reset state
    tick(); tick();
    check_all("reset", 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check_all("idle", 1'b0, 1'b0);

    // Absolute schedule with three channels
    cfg_write(0, 1'b1, 0, 3);
    cfg_write(2, 1'b1, 10, 1);
    cfg_write(3, 1'b1, 20, 4);
    run("sched", 1'b0, 1'b0, 1'b0);
    check("sched.fired_mask", 64'(fired), 64'(5'b01101));

    // Equal times
    disarm_all();
    cfg_write(1, 1'b1, 5, 7);
    cfg_write(4, 1'b1, 5, 7);
    run("equal", 1'b0, 1'b0, 1'b0);

    // Abort mid-run, then a full restart
    disarm_all();
    cfg_write(0, 1'b1, 0, 3);
    cfg_write(2, 1'b1, 10, 1);
    cfg_write(3, 1'b1, 20, 4);
    for (int i = 0; i < 3; i++) run("abort_rand", 1'b1, 1'b0, 1'b0);
    run("restart", 1'b0, 1'b0, 1'b0);

    // Nothing armed; writes during RUN and to out-of-range channels are dropped
    disarm_all();
    cfg_write(6, 1'b1, 3, 5);
    run("empty", 1'b0, 1'b1, 1'b0);
    run("empty_readback", 1'b0, 1'b0, 1'b0);

    // Chain-style pair and the maximum offset
    cfg_write(3, 1'b1, 20, 4);
    cfg_write(4, 1'b1, 30, 5);
    run("pair", 1'b0, 1'b0, 1'b0);
    disarm_all();
    cfg_write(1, 1'b1, 255, 6);
    run("tmax", 1'b0, 1'b0, 1'b0);

    // Random configurations
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < 3; j++)
        cfg_write(int'($urandom_range(0, 7)), 1'($urandom),
                  int'($urandom_range(0, 40)), int'($urandom_range(0, 7)));
      run("rand", ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));
    end

    // Reset in the middle of a run
    cfg_write(2, 1'b1, 30, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    model_reset();
    check_all("midrst1", 1'b0, 1'b0);
    tick();
    check_all("midrst2", 1'b0, 1'b0);
    rst_n = 1'b1;
    run("after_rst", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
